// File: rtl/cnn_pkg.sv
// cnn_pkg: shared CNN datapath constants and coefficient types
package cnn_pkg;
    localparam int IMAGE_WIDTH = 188;
    localparam int DATA_WIDTH  = 16;
    localparam int ACC_WIDTH   = 32;
    localparam int FRAC_BITS   = 8;
    localparam int SCALE_FRAC  = 8;
    localparam int NUM_CH      = 8;
    localparam int COL_W       = $clog2(IMAGE_WIDTH);
    localparam int CH_W        = $clog2(NUM_CH);
    localparam int PROD_W      = ACC_WIDTH + 16;

    typedef struct packed {
        logic [15:0]           scale;
        logic [DATA_WIDTH-1:0] bias;
    } coeff_t;

    localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = '0;
    localparam coeff_t COEFF_RESET = '{scale: 16'(1 << SCALE_FRAC), bias: '0};
endpackage

// File: rtl/bn_coeff_regfile.sv
// bn_coeff_regfile: per-channel scale/bias store, sync write, async read
module bn_coeff_regfile
    import cnn_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [CH_W-1:0]       waddr,
    input  logic [15:0]           wscale,
    input  logic [DATA_WIDTH-1:0] wbias,
    input  logic [CH_W-1:0]       raddr,
    output logic [15:0]           rscale,
    output logic [DATA_WIDTH-1:0] rbias
);
    coeff_t mem [NUM_CH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) mem[i] <= COEFF_RESET;
        end else if (we) begin
            mem[waddr] <= '{scale: wscale, bias: wbias};
        end
    end

    assign rscale = mem[raddr].scale;
    assign rbias  = mem[raddr].bias;
endmodule

// File: rtl/bn_relu_row_writer.sv
// bn_relu_row_writer: batch-norm, ReLU and saturation feeding a one-row FIFO
module bn_relu_row_writer
    import cnn_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ACC_WIDTH-1:0]  in_acc,
    input  logic                  cfg_we,
    input  logic [CH_W-1:0]       cfg_addr,
    input  logic [15:0]           cfg_scale,
    input  logic [DATA_WIDTH-1:0] cfg_bias,
    input  logic                  fifo_full,
    output logic                  fifo_wr_en,
    output logic [DATA_WIDTH-1:0] fifo_din,
    output logic [COL_W-1:0]      col_idx,
    output logic [CH_W-1:0]       ch_idx,
    output logic                  row_done
);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);
    localparam logic signed [PROD_W:0] ROUND_HALF = (PROD_W+1)'(1) <<< (SCALE_FRAC - 1);
    localparam logic signed [PROD_W:0] SAT_HI = (PROD_W+1)'(SAT_MAX);

    logic [15:0]                  rd_scale;
    logic [DATA_WIDTH-1:0]        rd_bias;
    logic                         s1_valid, s2_valid, s3_valid;
    logic                         s1_last, s2_last, s3_last;
    logic signed [PROD_W-1:0]     s1_prod;
    logic signed [DATA_WIDTH-1:0] s1_bias;
    logic signed [PROD_W:0]       s2_y, rnd, y_n;
    logic [DATA_WIDTH-1:0]        sat_n;
    logic                         advance, accept, last_col;

    bn_coeff_regfile u_coeff (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (cfg_we),
        .waddr  (cfg_addr),
        .wscale (cfg_scale),
        .wbias  (cfg_bias),
        .raddr  (ch_idx),
        .rscale (rd_scale),
        .rbias  (rd_bias)
    );

    assign advance    = !s3_valid || !fifo_full;
    assign in_ready   = advance;
    assign accept     = in_valid && advance;
    assign fifo_wr_en = s3_valid && !fifo_full;
    assign row_done   = fifo_wr_en && s3_last;
    assign last_col   = col_idx == COL_LAST;
    // widened by one bit so rounding and bias never wrap before saturation
    assign rnd   = ((PROD_W+1)'(s1_prod) + ROUND_HALF) >>> SCALE_FRAC;
    assign y_n   = rnd + (PROD_W+1)'(s1_bias);
    assign sat_n = s2_y[PROD_W] ? SAT_MIN : (s2_y > SAT_HI) ? SAT_MAX : s2_y[DATA_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {s1_valid, s2_valid, s3_valid} <= '0;
            {s1_last, s2_last, s3_last}    <= '0;
            s1_prod  <= '0;
            s1_bias  <= '0;
            s2_y     <= '0;
            fifo_din <= '0;
            col_idx  <= '0;
            ch_idx   <= '0;
        end else if (advance) begin
            s1_valid <= accept;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
            s2_last  <= s1_last;
            s3_last  <= s2_last;
            s2_y     <= y_n;
            fifo_din <= sat_n;
            if (accept) begin
                s1_prod <= $signed(in_acc) * $signed(rd_scale);
                s1_bias <= $signed(rd_bias);
                s1_last <= last_col;
                col_idx <= last_col ? '0 : col_idx + 1'b1;
                if (last_col) ch_idx <= (ch_idx == CH_LAST) ? '0 : ch_idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bn_relu_row_writer.sv
// tb_bn_relu_row_writer: scoreboard bench for the BN/ReLU row writer
module tb_bn_relu_row_writer;
    import cnn_pkg::*;

    logic clk = 0, rst_n = 0, in_valid = 0, cfg_we = 0, fifo_full = 0;
    logic in_ready, fifo_wr_en, row_done;
    logic [ACC_WIDTH-1:0]  in_acc = '0;
    logic [CH_W-1:0]       cfg_addr = '0;
    logic [15:0]           cfg_scale = '0;
    logic [DATA_WIDTH-1:0] cfg_bias = '0;
    logic [DATA_WIDTH-1:0] fifo_din;
    logic [COL_W-1:0]      col_idx;
    logic [CH_W-1:0]       ch_idx;

    typedef struct {
        logic [15:0] data;
        logic        last;
        int          cyc;
    } exp_t;

    exp_t    sb[$];
    int      checks = 0, errors = 0, cyc = 0;
    int      writes = 0, stalls = 0, row_pulses = 0;
    int      m_col = 0, m_ch = 0, w0, s0;
    bit      strict_lat = 1;
    shortint m_scale [NUM_CH];
    shortint m_bias  [NUM_CH];

    bn_relu_row_writer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_acc     (in_acc),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_scale  (cfg_scale),
        .cfg_bias   (cfg_bias),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .col_idx    (col_idx),
        .ch_idx     (ch_idx),
        .row_done   (row_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [31:0] acc, input int ch);
        longint p, y;
        p = longint'($signed(acc)) * longint'(m_scale[ch]);
        y = ((p + 128) >>> SCALE_FRAC) + longint'(m_bias[ch]);
        return (y < 0) ? 16'h0000 : (y > 32767) ? 16'h7fff : y[15:0];
    endfunction

    task automatic reset_model();
        for (int i = 0; i < NUM_CH; i++) begin
            m_scale[i] = 256;
            m_bias[i]  = 0;
        end
        m_col = 0;
        m_ch  = 0;
        sb.delete();
    endtask

    // exp < 0 means derive the expected word from the reference model
    task automatic send(input logic [31:0] acc, input int exp = -1);
        exp_t e;
        int n = 0;
        in_valid = 1;
        in_acc   = acc;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("accept_timeout", in_ready, 1);
        check("col_idx", col_idx, m_col);
        check("ch_idx", ch_idx, m_ch);
        e.data = (exp < 0) ? model(acc, m_ch) : 16'(exp);
        e.last = (m_col == IMAGE_WIDTH - 1);
        e.cyc  = cyc;
        sb.push_back(e);
        if (m_col == IMAGE_WIDTH - 1) begin
            m_col = 0;
            m_ch  = (m_ch + 1) % NUM_CH;
        end else begin
            m_col++;
        end
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic cfg(input int ch, input int scale, input int bias);
        cfg_we    = 1;
        cfg_addr  = CH_W'(ch);
        cfg_scale = 16'(scale);
        cfg_bias  = 16'(bias);
        @(posedge clk);
        #1 cfg_we = 0;
        m_scale[ch] = 16'(scale);
        m_bias[ch]  = 16'(bias);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (!in_ready) begin
                stalls++;
                check("stall_only_when_full", fifo_full, 1);
            end
            if (row_done && !fifo_wr_en) check("row_done_without_write", row_done, 0);
            if (fifo_wr_en) begin
                writes++;
                if (row_done) row_pulses++;
                if (sb.size() == 0) begin
                    check("unexpected_write", fifo_wr_en, 0);
                end else begin
                    e = sb.pop_front();
                    check("fifo_din", fifo_din, e.data);
                    check("row_done", row_done, e.last);
                    if (strict_lat) check("latency", cyc - e.cyc, 3);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_model();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_wr_en", fifo_wr_en, 0);
        check("rst_row_done", row_done, 0);
        check("rst_din", fifo_din, 0);
        check("rst_col", col_idx, 0);
        check("rst_ch", ch_idx, 0);
        @(posedge clk);
        #1;

        send(32'h0000_0300, 'h0300);
        send(-32'sh100, 'h0000);
        drain();

        cfg(0, 384, 'h80);
        send(32'h200, 'h0380);
        send(32'h1, 'h0082);
        send(-32'sh1, 'h007f);
        cfg_we = 1; cfg_addr = 0; cfg_scale = 16'd512; cfg_bias = 16'h0080;
        send(32'h100, 'h0200);
        cfg_we = 0;
        m_scale[0] = 512;
        send(32'h100, 'h0280);
        drain();

        cfg(0, 'h7fff, 'h80);
        send(32'h0010_0000, 'h7fff);
        cfg(0, -256, 'h80);
        send(32'h100, 'h0000);
        send(-32'sh1000, 'h1080);
        cfg(0, 256, 0);
        send(32'h7fff, 'h7fff);
        send(32'h8000, 'h7fff);
        drain();

        strict_lat = 0;
        w0 = writes;
        s0 = stalls;
        fork
            for (int i = 0; i < 10; i++) send(32'((i + 1) << 8), (i + 1) << 8);
            begin
                repeat (4) @(posedge clk);
                #1 fifo_full = 1;
                repeat (6) @(posedge clk);
                #1 fifo_full = 0;
            end
        join
        drain();
        check("bp_write_count", writes - w0, 10);
        check("bp_stalled", (stalls - s0) > 0, 1);
        strict_lat = 1;

        cfg(0, 512, 'h40);
        fifo_full = 1;
        send(32'h100);
        send(32'h200);
        send(32'h300);
        @(negedge clk);
        check("full_stall", in_ready, 0);
        check("full_no_write", fifo_wr_en, 0);
        rst_n = 0;
        @(posedge clk);
        #1 rst_n = 1;
        reset_model();
        fifo_full = 0;
        @(negedge clk);
        check("mid_rst_wr_en", fifo_wr_en, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_col", col_idx, 0);
        check("mid_rst_ch", ch_idx, 0);
        check("mid_rst_din", fifo_din, 0);
        w0 = writes;
        repeat (6) @(negedge clk);
        check("mid_rst_no_writes", writes - w0, 0);
        @(posedge clk);
        #1;

        cfg(1, 256, 'h100);
        row_pulses = 0;
        send(32'h300, 'h0300);
        for (int i = 1; i < 2 * IMAGE_WIDTH; i++) send(32'h100 + 32'(i));
        drain();
        check("row_pulses", row_pulses, 2);
        check("rows_ch_after", ch_idx, 2);
        check("rows_col_after", col_idx, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
